qam_tx_gen: RTL and testbench
=============================

QAM_TX_GEN -- requirements
Module: qam_tx_gen

Interface
REQ-001 SHALL have parameter BITS_PER_SYM, default 4, bits per symbol; legal values 2, 4, 6, 8 (QPSK, 16-, 64-, 256-QAM).
REQ-002 SHALL have parameter UPSAMPLE, default 11, samples per symbol; legal range 1..64.
REQ-003 SHALL have parameter OUT_W, default 16, output sample width; legal range 8..24.
REQ-004 SHALL have parameter SHIFT, default 0, left-shift gain applied to constellation amplitude; legal range 0..OUT_W-5.
REQ-005 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-006 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port en, input, 1, stream enable.
REQ-008 SHALL have port hold_mode, input, 1: 0 = zero-stuff, 1 = sample-hold between symbols.
REQ-009 SHALL have port dout_ready, input, 1, downstream accepts the current sample.
REQ-010 SHALL have port dout_valid, output, 1, dout_i/dout_q hold a valid sample.
REQ-011 SHALL have port dout_i, output, OUT_W, signed in-phase sample.
REQ-012 SHALL have port dout_q, output, OUT_W, signed quadrature sample.
REQ-013 SHALL have port sym_strobe, output, 1, pulses for one cycle when a phase-0 sample is accepted.

Function
REQ-014 SHALL generate data with a PRBS-15 Fibonacci LFSR: out bit = s[14]; feedback = s[14] xor s[13]; shift left, feedback into s[0].
REQ-015 SHALL advance the LFSR by exactly BITS_PER_SYM steps per symbol, in one cycle; first output bit = symbol MSB.
REQ-016 SHALL split each symbol into upper half (I) and lower half (Q) index fields, each H = BITS_PER_SYM/2 bits wide, with L = 2^H levels.
REQ-017 SHALL map index k to amplitude 2k-(L-1), e.g. 16-QAM gives -3,-1,+1,+3; SHALL then left-shift by SHIFT and sign-extend to OUT_W without overflow.
REQ-018 SHALL keep a phase counter 0..UPSAMPLE-1, advanced only when a sample loads into the output register; SHALL wrap from UPSAMPLE-1 to 0.
REQ-019 SHALL take a new symbol only at phase 0; for phases other than 0, SHALL output 0 if hold_mode=0, else repeat the last symbol's I/Q.
REQ-020 SHALL treat every sample as phase 0 when UPSAMPLE=1.
REQ-021 SHALL use a registered output: when en=1 and (dout_valid=0 or dout_ready=1), SHALL load the next sample and set dout_valid=1 on the next edge.
REQ-022 SHALL keep dout_i, dout_q and dout_valid stable while dout_valid=1 and dout_ready=0 (backpressure); the LFSR and phase SHALL not advance.
REQ-023 SHALL, when en=0, load nothing; a pending sample SHALL remain until accepted, after which dout_valid=0.
REQ-024 SHALL sample hold_mode at load time; a change affects only samples loaded afterwards.
REQ-025 SHALL assert sym_strobe for the cycle in which dout_valid=1, dout_ready=1 and the presented sample is phase 0.
REQ-026 SHALL produce the first valid sample one cycle after the first edge with en=1 following reset release.

Reset
REQ-027 SHALL, on rstn=0, immediately set dout_valid=0, dout_i=0, dout_q=0, sym_strobe=0, phase=0, held symbol=0 and LFSR=15'h7FFF.
REQ-028 SHALL, on reset assertion mid-stream, discard any pending sample; after release, the sequence SHALL restart bit-identically from the seed.

Configuration
REQ-029 SHALL, with macro QAM_TX_GRAY_EN defined, treat each H-bit index field as Gray code and convert it to binary k before REQ-017; without the macro, the field SHALL be used as k directly.

Verification
REQ-030 SHALL cover: defaults, no macro, en=1, ready=1 after reset -> first sample I=+3, Q=+3, then 10 zero samples, then the next symbol; sym_strobe every 11th accepted sample.
REQ-031 SHALL cover: as REQ-030 with QAM_TX_GRAY_EN -> first sample I=+1, Q=+1.
REQ-032 SHALL cover: hold_mode=1, UPSAMPLE=4 -> each symbol value repeated on 4 consecutive accepted samples.
REQ-033 SHALL cover: dout_ready held low 5 cycles mid-symbol -> outputs frozen; the sample sequence after release is identical to the no-stall reference.
REQ-034 SHALL cover: BITS_PER_SYM=6, SHIFT=2 -> all I/Q in {-28,-20,-12,-4,4,12,20,28}; the first sample is +28/+28 without the macro.
REQ-035 SHALL cover: rstn pulsed low mid-symbol -> dout_valid=0 asynchronously; after restart the first sample equals the post-reset first sample of REQ-030.

Source files
------------

// File: rtl/qam_tx_gen.sv
// qam_tx_gen: PRBS-15 driven QAM baseband symbol generator with integer
// upsampling (zero-stuff or sample-hold) and a valid/ready output register.
// Optional feature: define QAM_TX_GRAY_EN to treat each I/Q index field as
// Gray code before mapping it to a constellation level.
module qam_tx_gen #(
  parameter int BITS_PER_SYM = 4,
  parameter int UPSAMPLE     = 11,
  parameter int OUT_W        = 16,
  parameter int SHIFT        = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             hold_mode,
  input  logic             dout_ready,
  output logic             dout_valid,
  output logic [OUT_W-1:0] dout_i,
  output logic [OUT_W-1:0] dout_q,
  output logic             sym_strobe
);

  localparam int H    = BITS_PER_SYM / 2;
  localparam int L    = 1 << H;
  localparam int PH_W = (UPSAMPLE > 1) ? $clog2(UPSAMPLE) : 1;
  localparam logic [14:0] SEED = 15'h7FFF;

  logic [14:0]             lfsr;
  logic [14:0]             lfsr_next;
  logic [BITS_PER_SYM-1:0] sym_bits;
  logic [OUT_W-1:0]        new_i;
  logic [OUT_W-1:0]        new_q;
  logic [OUT_W-1:0]        held_i;
  logic [OUT_W-1:0]        held_q;
  logic [PH_W-1:0]         phase;
  logic [PH_W-1:0]         phase_next;
  logic                    at_sym;
  logic                    out_ph0;
  logic                    load;

  // Index field to signed constellation level: 2k-(L-1), then gain shift.
  // The level fits in 5 signed bits, so the shift never overflows OUT_W.
  function automatic logic [OUT_W-1:0] to_level(input logic [H-1:0] field);
    logic [H-1:0]     k;
    logic [OUT_W-1:0] lvl;
`ifdef QAM_TX_GRAY_EN
    k[H-1] = field[H-1];
    for (int b = H - 2; b >= 0; b--) begin
      k[b] = k[b+1] ^ field[b];
    end
`else
    k = field;
`endif
    lvl = OUT_W'({k, 1'b0}) - OUT_W'(L - 1);
    return lvl << SHIFT;
  endfunction

  // Run the LFSR BITS_PER_SYM steps ahead; first bit out lands in the symbol MSB.
  always_comb begin
    logic [14:0]             s;
    logic [BITS_PER_SYM-1:0] sym;
    s   = lfsr;
    sym = '0;
    for (int n = 0; n < BITS_PER_SYM; n++) begin
      sym = {sym[BITS_PER_SYM-2:0], s[14]};
      s   = {s[13:0], s[14] ^ s[13]};
    end
    lfsr_next = s;
    sym_bits  = sym;
  end

  assign new_i = to_level(sym_bits[BITS_PER_SYM-1 -: H]);
  assign new_q = to_level(sym_bits[H-1:0]);

  // Phase of the sample about to be loaded, and where it goes next.
  always_comb begin
    at_sym     = (phase == '0);
    phase_next = '0;
    if (UPSAMPLE > 1 && phase != PH_W'(UPSAMPLE - 1)) begin
      phase_next = phase + PH_W'(1);
    end
  end

  // A new sample enters the output register when the slot is empty or being drained.
  assign load = en & (~dout_valid | dout_ready);

  // Output register, phase counter, held symbol and LFSR; everything advances only on a load.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lfsr       <= SEED;
      phase      <= '0;
      held_i     <= '0;
      held_q     <= '0;
      dout_i     <= '0;
      dout_q     <= '0;
      dout_valid <= 1'b0;
      out_ph0    <= 1'b0;
    end else if (load) begin
      dout_valid <= 1'b1;
      out_ph0    <= at_sym;
      phase      <= phase_next;
      if (at_sym) begin
        lfsr   <= lfsr_next;
        held_i <= new_i;
        held_q <= new_q;
        dout_i <= new_i;
        dout_q <= new_q;
      end else if (hold_mode) begin
        dout_i <= held_i;
        dout_q <= held_q;
      end else begin
        dout_i <= '0;
        dout_q <= '0;
      end
    end else if (dout_ready) begin
      dout_valid <= 1'b0;
    end
  end

  // Symbol boundary marker, live only while a phase-0 sample is being accepted.
  assign sym_strobe = dout_valid & dout_ready & out_ph0;

endmodule

// File: tb/tb_qam_tx_gen.sv
// tb_qam_tx_gen: scoreboard bench for qam_tx_gen. Three instances cover the
// default 16-QAM/x11 stream, a 16-QAM/x4 sample-hold stream and a 64-QAM
// shift-2 stream with no upsampling. Expected symbols are hand-derived from
// the all-ones PRBS-15 seed; the Gray tables apply when QAM_TX_GRAY_EN is set.
module tb_qam_tx_gen;

  typedef struct packed {
    logic signed [15:0] i;
    logic signed [15:0] q;
    logic               s;
  } smp_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en    [3];
  logic        ready [3];
  logic        hold  [3];
  logic        ov    [3];
  logic        os    [3];
  logic [15:0] oi    [3];
  logic [15:0] oq    [3];

  smp_t sb0[$];
  smp_t sb1[$];
  smp_t sb2[$];

  int checks = 0;
  int errors = 0;

`ifdef QAM_TX_GRAY_EN
  int t4i [8] = '{1, 1, 1, 1, -3, -3, -3, -1};
  int t4q [8] = '{1, 1, 1, 3, -3, -3, -3, -3};
  int t6i [6] = '{12, 12, 12, -28, -28, -28};
  int t6q [6] = '{12, 12, -28, -28, -20, -28};
`else
  int t4i [8] = '{3, 3, 3, 3, -3, -3, -3, -1};
  int t4q [8] = '{3, 3, 3, 1, -3, -3, -3, -3};
  int t6i [6] = '{28, 28, 28, -28, -28, -28};
  int t6q [6] = '{28, 28, -28, -28, -20, -28};
`endif

  qam_tx_gen #(.BITS_PER_SYM(4), .UPSAMPLE(11), .OUT_W(16), .SHIFT(0)) dut_a (
    .clk(clk), .rstn(rstn), .en(en[0]), .hold_mode(hold[0]), .dout_ready(ready[0]),
    .dout_valid(ov[0]), .dout_i(oi[0]), .dout_q(oq[0]), .sym_strobe(os[0]));

  qam_tx_gen #(.BITS_PER_SYM(4), .UPSAMPLE(4), .OUT_W(16), .SHIFT(0)) dut_b (
    .clk(clk), .rstn(rstn), .en(en[1]), .hold_mode(hold[1]), .dout_ready(ready[1]),
    .dout_valid(ov[1]), .dout_i(oi[1]), .dout_q(oq[1]), .sym_strobe(os[1]));

  qam_tx_gen #(.BITS_PER_SYM(6), .UPSAMPLE(1), .OUT_W(16), .SHIFT(2)) dut_c (
    .clk(clk), .rstn(rstn), .en(en[2]), .hold_mode(hold[2]), .dout_ready(ready[2]),
    .dout_valid(ov[2]), .dout_i(oi[2]), .dout_q(oq[2]), .sym_strobe(os[2]));

  // 100 MHz clock
  always #5 clk = ~clk;

  // Reference sample n of a stream: symbol n/UPSAMPLE at phase 0, else zero or held.
  function automatic smp_t expected(input int inst, input int idx, input bit hm);
    int   ups;
    int   ph;
    int   sym;
    int   vi;
    int   vq;
    smp_t e;
    ups = (inst == 0) ? 11 : (inst == 1) ? 4 : 1;
    ph  = idx % ups;
    sym = idx / ups;
    if (inst == 2) begin
      vi = t6i[sym];
      vq = t6q[sym];
    end else begin
      vi = t4i[sym];
      vq = t4q[sym];
    end
    if (ph != 0 && !hm) begin
      vi = 0;
      vq = 0;
    end
    e.i = 16'(vi);
    e.q = 16'(vq);
    e.s = (ph == 0);
    return e;
  endfunction

  function automatic int sb_size(input int inst);
    case (inst)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  function automatic smp_t sb_head(input int inst);
    case (inst)
      0:       return sb0[0];
      1:       return sb1[0];
      default: return sb2[0];
    endcase
  endfunction

  task automatic sb_push(input int inst, input smp_t e);
    case (inst)
      0:       sb0.push_back(e);
      1:       sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  task automatic sb_pop(input int inst, output smp_t e);
    case (inst)
      0:       e = sb0.pop_front();
      1:       e = sb1.pop_front();
      default: e = sb2.pop_front();
    endcase
  endtask

  task automatic check_output(input string name, input smp_t act, input smp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got i=%0d q=%0d strobe=%0b, expected i=%0d q=%0d strobe=%0b",
               name, $time, act.i, act.q, act.s, exp.i, exp.q, exp.s);
    end
  endtask

  task automatic check_value(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // One scoreboard step per instance: pop on accept, otherwise the pending sample must hold still.
  task automatic monitor_step(input int inst);
    smp_t act;
    smp_t e;
    act.i = oi[inst];
    act.q = oq[inst];
    act.s = os[inst];
    if (ov[inst] === 1'b1) begin
      if (sb_size(inst) == 0) begin
        if (ready[inst]) check_value($sformatf("unexpected_sample%0d", inst), 1, 0);
      end else if (ready[inst]) begin
        sb_pop(inst, e);
        check_output($sformatf("sample%0d", inst), act, e);
      end else begin
        e   = sb_head(inst);
        e.s = 1'b0;
        check_output($sformatf("stall%0d", inst), act, e);
      end
    end
  endtask

  // Monitor samples on the falling edge, away from the register updates.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      for (int k = 0; k < 3; k++) monitor_step(k);
    end
  end

  // Assert reset, confirm every instance is cleared, then release.
  task automatic reset_all();
    rstn = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      en[k] = 1'b0;
      check_value($sformatf("reset_state%0d", k),
                  int'({ov[k], oi[k], oq[k], os[k]}), 0);
    end
    sb0.delete();
    sb1.delete();
    sb2.delete();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // Queue n expected samples, then stream them with an optional 5-cycle stall
  // after stall_at samples have been loaded.
  task automatic apply_stimulus(input int inst, input int n, input int stall_at, input bit hm);
    for (int k = 0; k < n; k++) sb_push(inst, expected(inst, k, hm));
    hold[inst]  = hm;
    ready[inst] = 1'b1;
    en[inst]    = 1'b1;
    check_value($sformatf("latency_pre%0d", inst), int'(ov[inst]), 0);
    @(posedge clk);
    #1 check_value($sformatf("latency_first%0d", inst), int'(ov[inst]), 1);
    if (stall_at > 0) begin
      repeat (stall_at - 1) @(posedge clk);
      #1 ready[inst] = 1'b0;
      repeat (5) @(posedge clk);
      #1 ready[inst] = 1'b1;
      repeat (n - stall_at) @(posedge clk);
    end else begin
      repeat (n - 1) @(posedge clk);
    end
    #1 en[inst] = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_value($sformatf("drain%0d", inst), sb_size(inst), 0);
    check_value($sformatf("idle_valid%0d", inst), int'(ov[inst]), 0);
  endtask

  initial begin
    rstn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      en[k]    = 1'b0;
      ready[k] = 1'b1;
      hold[k]  = 1'b0;
    end
    #3;

    // Default stream: symbol then ten zeros, strobe every 11th sample.
    reset_all();
    apply_stimulus(0, 40, -1, 1'b0);

    // Same stream with a 5-cycle backpressure stall on the sample of symbol 3.
    reset_all();
    apply_stimulus(0, 40, 34, 1'b0);

    // Asynchronous reset mid-symbol, then a restart from the seed.
    reset_all();
    for (int k = 0; k < 20; k++) sb_push(0, expected(0, k, 1'b0));
    en[0] = 1'b1;
    repeat (15) @(posedge clk);
    #3 rstn = 1'b0;
    #1 check_value("async_reset", int'({ov[0], oi[0], oq[0]}), 0);
    sb0.delete();
    en[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    apply_stimulus(0, 12, -1, 1'b0);

    // Sample-hold with four samples per symbol.
    reset_all();
    apply_stimulus(1, 20, -1, 1'b1);

    // 64-QAM with gain shift 2, one sample per symbol.
    reset_all();
    apply_stimulus(2, 6, -1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
